// File: rtl/memory_responder_pkg.sv
// Shared constants for the memory responder: bus widths, I/O page layout and STATUS bits.
package memory_responder_pkg;

    localparam int          PR_ADDR_W   = 16;
    localparam logic [15:0] MEM_IO_BASE = 16'hFF00;

    localparam logic [3:0] IO_TXDATA = 4'h0;
    localparam logic [3:0] IO_STATUS = 4'h1;
    localparam logic [3:0] IO_RXDATA = 4'h2;
    localparam logic [3:0] IO_RXPOP  = 4'h3;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_TXOVF       = 3;

endpackage

// File: rtl/memory_responder_if.sv
// Pipeline memory bus plus the TX/RX byte-stream links seen by the memory responder.
// Handshake: a byte moves on a clock edge exactly when valid & ready are both high at that edge;
// valid never waits on ready, and the offered data stays put until it is taken.
interface memory_responder_if;
    import memory_responder_pkg::*;

    logic [PR_ADDR_W-1:0] mem_addr;
    logic                 mem_store;
    logic [7:0]           mem_dout;
    logic [7:0]           mem_din;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output mem_addr, mem_store, mem_dout, tx_ready, rx_data, rx_valid,
        input  mem_din, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  mem_addr, mem_store, mem_dout, tx_ready, rx_data, rx_valid,
        output mem_din, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/memory_responder_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; a push and a pop may share a cycle, even when full.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0] mem [0:DEPTH-1];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic do_pop;
    logic do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head    = mem[rptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/memory_responder.sv
// Memory-side end of the load/store bus: read-first byte RAM with one-cycle read latency,
// plus a 16-byte I/O page fronting a TX FIFO and an RX FIFO.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int          RAM_ADDR_W = 16,
    parameter logic [15:0] IO_BASE    = MEM_IO_BASE,
    parameter int          FIFO_DEPTH = 8
) (
    input logic                clk,
    input logic                rst,
    memory_responder_if.slave  bus
);
    logic [7:0] ram [0:2**RAM_ADDR_W-1];

    logic                  io_sel;
    logic [3:0]            io_off;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  wr;
    logic                  ram_we;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  status_clr;
    logic                  rx_pop;
    logic                  rx_push;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  rx_full;
    logic                  rx_empty;
    logic [7:0]            tx_head;
    logic [7:0]            rx_head;
    logic                  txovf;
    logic [7:0]            status;
    logic [7:0]            rd_data;

    assign io_sel  = (bus.mem_addr[15:4] == IO_BASE[15:4]);
    assign io_off  = bus.mem_addr[3:0];
    assign ram_idx = bus.mem_addr[RAM_ADDR_W-1:0];

    // Only stores have side effects; idle address traffic never touches FIFO state.
    assign wr         = bus.mem_store && !rst;
    assign ram_we     = wr && !io_sel;
    assign tx_push    = wr && io_sel && (io_off == IO_TXDATA);
    assign status_clr = wr && io_sel && (io_off == IO_STATUS);
    assign rx_pop     = wr && io_sel && (io_off == IO_RXPOP);
    assign tx_pop     = !tx_empty && bus.tx_ready;
    assign rx_push    = bus.rx_valid && !rx_full;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (bus.mem_dout),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (bus.rx_data),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign bus.tx_data  = tx_head;
    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = !rx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            txovf <= 1'b0;
        end else if (tx_push && tx_full && !tx_pop) begin
            txovf <= 1'b1;
        end else if (status_clr) begin
            txovf <= 1'b0;
        end
    end

    always_comb begin
        status                 = '0;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_RX_NONEMPTY] = !rx_empty;
        status[ST_TXOVF]       = txovf;
    end

    always_comb begin
        rd_data = '0;
        if (io_sel) begin
            case (io_off)
                IO_STATUS: rd_data = status;
                IO_RXDATA: rd_data = rx_empty ? 8'h00 : rx_head;
                default:   rd_data = '0;
            endcase
        end else begin
            rd_data = ram[ram_idx];
        end
    end

    // Read-first: the RAM write below lands after this edge's read has been captured.
    always_ff @(posedge clk) begin
        if (rst) bus.mem_din <= '0;
        else     bus.mem_din <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= bus.mem_dout;
    end
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: RAM latency, I/O page side effects, TX/RX FIFO flow and reset.
module tb_memory_responder;
    import memory_responder_pkg::*;

    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       ovf_m;

    memory_responder_if mif();

    memory_responder #(
        .RAM_ADDR_W (16),
        .IO_BASE    (MEM_IO_BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] io_exp(input logic [3:0] off);
        logic [7:0] v;
        v = 8'h00;
        if (off == IO_STATUS) begin
            v[ST_TXOVF]       = ovf_m;
            v[ST_RX_NONEMPTY] = (rx_q.size() != 0);
            v[ST_TX_EMPTY]    = (exp_q.size() == 0);
            v[ST_TX_FULL]     = (exp_q.size() == DEPTH);
        end else if (off == IO_RXDATA) begin
            v = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        end
        return v;
    endfunction

    // Advance one edge; the model applies the same edge's effects and checks handshakes.
    task automatic tick();
        bit         tx_pop;
        bit         rx_acc;
        bit         tx_was_full;
        bit         io;
        logic [3:0] off;
        if (rst) begin
            exp_q.delete();
            rx_q.delete();
            ovf_m = 1'b0;
        end else begin
            tx_was_full = (exp_q.size() == DEPTH);
            tx_pop      = mif.tx_ready && (exp_q.size() != 0);
            rx_acc      = mif.rx_valid && (rx_q.size() < DEPTH);
            io          = (mif.mem_addr[15:4] == MEM_IO_BASE[15:4]);
            off         = mif.mem_addr[3:0];
            if (tx_pop) begin
                check("tx_valid", {7'b0, mif.tx_valid}, 8'h01);
                check("tx_data", mif.tx_data, exp_q.pop_front());
            end
            if (mif.rx_valid) check("rx_ready", {7'b0, mif.rx_ready}, {7'b0, rx_acc});
            if (mif.mem_store && io) begin
                if (off == IO_TXDATA) begin
                    if (tx_was_full && !tx_pop) ovf_m = 1'b1;
                    else exp_q.push_back(mif.mem_dout);
                end else if (off == IO_STATUS) begin
                    ovf_m = 1'b0;
                end else if (off == IO_RXPOP) begin
                    if (rx_q.size() != 0) void'(rx_q.pop_front());
                end
            end
            if (rx_acc) rx_q.push_back(mif.rx_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [15:0] addr, input logic [7:0] data);
        mif.mem_addr  = addr;
        mif.mem_dout  = data;
        mif.mem_store = 1'b1;
        tick();
        mif.mem_store = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        mif.mem_addr  = addr;
        mif.mem_store = 1'b0;
        tick();
        check(tag, mif.mem_din, exp);
    endtask

    task automatic read_io(input string tag, input logic [3:0] off);
        logic [7:0] exp;
        exp = io_exp(off);
        read_check(tag, MEM_IO_BASE | {12'h000, off}, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ovf_m = 1'b0;
        rst   = 1'b1;
        mif.mem_addr  = 16'h0000;
        mif.mem_store = 1'b0;
        mif.mem_dout  = 8'h00;
        mif.tx_ready  = 1'b0;
        mif.rx_data   = 8'h00;
        mif.rx_valid  = 1'b0;
        tick();
        tick();
        check("reset_mem_din", mif.mem_din, 8'h00);
        check("reset_tx_valid", {7'b0, mif.tx_valid}, 8'h00);
        check("reset_rx_ready", {7'b0, mif.rx_ready}, 8'h01);
        rst = 1'b0;
        read_check("reset_status", MEM_IO_BASE | 16'h0001, 8'h02);

        // RAM latency and read-first behaviour
        write(16'h0123, 8'hA5);
        read_check("ram_read", 16'h0123, 8'hA5);
        write(16'h0123, 8'h5A);
        read_check("ram_rewrite", 16'h0123, 8'h5A);
        mif.mem_dout  = 8'h77;
        mif.mem_store = 1'b1;
        tick();
        mif.mem_store = 1'b0;
        check("read_first", mif.mem_din, 8'h5A);
        read_check("after_store", 16'h0123, 8'h77);
        read_check("io_unused", MEM_IO_BASE | 16'h0007, 8'h00);

        // Idle RXDATA reads must not pop
        mif.rx_valid = 1'b1;
        mif.rx_data  = 8'h3C;
        tick();
        mif.rx_data  = 8'h4D;
        tick();
        mif.rx_valid = 1'b0;
        mif.mem_addr = MEM_IO_BASE | 16'h0002;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rxdata_hold", mif.mem_din, 8'h3C);
        end
        read_io("rx_status", IO_STATUS);
        write(MEM_IO_BASE | 16'h0003, 8'h00);
        read_io("rx_next", IO_RXDATA);
        write(MEM_IO_BASE | 16'h0003, 8'h00);
        read_check("rx_empty_zero", MEM_IO_BASE | 16'h0002, 8'h00);
        write(MEM_IO_BASE | 16'h0003, 8'h00);
        read_io("rx_pop_empty", IO_STATUS);

        // TX overflow and sticky flag
        for (int i = 0; i <= DEPTH; i++) write(MEM_IO_BASE, 8'h10 + 8'(i));
        read_check("tx_ovf_status", MEM_IO_BASE | 16'h0001, 8'h09);
        read_check("txdata_read", MEM_IO_BASE, 8'h00);
        write(MEM_IO_BASE | 16'h0001, 8'hFF);
        read_check("ovf_cleared", MEM_IO_BASE | 16'h0001, 8'h01);

        // Push while full with a simultaneous pop
        mif.tx_ready = 1'b1;
        write(MEM_IO_BASE, 8'h20);
        mif.tx_ready = 1'b0;
        read_check("full_push_pop", MEM_IO_BASE | 16'h0001, 8'h01);
        mif.mem_addr = 16'h0040;
        mif.tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        mif.tx_ready = 1'b0;
        check("tx_drained", {7'b0, mif.tx_valid}, 8'h00);
        check("tx_model_empty", 8'(exp_q.size()), 8'h00);

        // RX fill past depth, then pop with a byte still offered
        mif.rx_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            mif.rx_data = 8'h30 + 8'(i);
            tick();
        end
        check("rx_full_ready", {7'b0, mif.rx_ready}, 8'h00);
        mif.rx_data = 8'h99;
        write(MEM_IO_BASE | 16'h0003, 8'h00);
        mif.rx_valid = 1'b0;
        check("rx_ready_back", {7'b0, mif.rx_ready}, 8'h01);
        read_check("rx_after_pop", MEM_IO_BASE | 16'h0002, 8'h31);

        // Reset with both FIFOs half full; coincident store is dropped
        for (int i = 0; i < 3; i++) write(MEM_IO_BASE | 16'h0003, 8'h00);
        for (int i = 0; i < DEPTH / 2; i++) write(MEM_IO_BASE, 8'h50 + 8'(i));
        read_io("half_status", IO_STATUS);
        rst = 1'b1;
        mif.mem_addr  = 16'h0123;
        mif.mem_dout  = 8'hEE;
        mif.mem_store = 1'b1;
        tick();
        mif.mem_store = 1'b0;
        check("rst_mem_din", mif.mem_din, 8'h00);
        check("rst_tx_valid", {7'b0, mif.tx_valid}, 8'h00);
        check("rst_rx_ready", {7'b0, mif.rx_ready}, 8'h01);
        rst = 1'b0;
        read_check("rst_status", MEM_IO_BASE | 16'h0001, 8'h02);
        read_check("rst_store_ignored", 16'h0123, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
